icache_dm: RTL and testbench

Direct-mapped instruction cache sitting between the fetch stage and the memory-bus arbiter's instruction port. It serves 64-bit aligned fetch words on a hit. On a miss it requests a 64-byte line fill over the irequest/ireqack/idone handshake, installs the line and returns the requested word. It also supports a full invalidate (flush) and keeps hit/miss counters.

---
 rtl/icache_if.sv | 26 ++
 rtl/icache_dm.sv | 149 ++++++++++++++
 tb/tb_icache_dm.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/icache_if.sv
// Fetch-side and arbiter-side signals of the direct-mapped instruction cache.
// The cache takes the slave modport; the fetch stage and arbiter drive the master side.
interface icache_if;
    logic         fetch_req;
    logic [63:0]  fetch_addr;
    logic         fetch_valid;
    logic [63:0]  fetch_data;
    logic         flush;
    logic         irequest;
    logic         ireqack;
    logic [63:0]  iaddr;
    logic [511:0] idata;
    logic         idone;
    logic [31:0]  hit_count;
    logic [31:0]  miss_count;

    modport slave (
        input  fetch_req, fetch_addr, flush, ireqack, idata, idone,
        output fetch_valid, fetch_data, irequest, iaddr, hit_count, miss_count
    );

    modport master (
        output fetch_req, fetch_addr, flush, ireqack, idata, idone,
        input  fetch_valid, fetch_data, irequest, iaddr, hit_count, miss_count
    );
endinterface

// File: rtl/icache_dm.sv
// Direct-mapped instruction cache: 64-byte lines, 64-bit fetch words,
// line fill through the arbiter irequest/ireqack/idone handshake.
module icache_dm #(
    parameter int SETS = 64
) (
    input logic     clk,
    input logic     reset,
    icache_if.slave bus
);
    // state     | meaning
    // IDLE      | waiting for fetch_req
    // LOOKUP    | tag compare on latched request address
    // MISS_REQ  | irequest held until ireqack
    // MISS_WAIT | waiting for idone carrying the fill line
    // RESP      | fetch_valid pulse, fetch_req not sampled
    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = 58 - IDX_W;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        MISS_REQ,
        MISS_WAIT,
        RESP
    } state_t;

    state_t state, state_nxt;

    logic [63:3]      req_addr;
    logic [SETS-1:0]  valid;
    logic             drop;
    logic [TAG_W-1:0] tag_mem  [SETS];
    logic [511:0]     data_mem [SETS];

    logic             fetch_valid_q;
    logic [63:0]      fetch_data_q;
    logic             irequest_q;
    logic [63:0]      iaddr_q;
    logic [31:0]      hit_count_q;
    logic [31:0]      miss_count_q;

    logic [IDX_W-1:0] idx;
    logic [TAG_W-1:0] tag;
    logic [8:0]       word_lsb;
    logic             hit;
    logic             install;
    logic             unused_addr_bits;

    assign idx      = req_addr[6 +: IDX_W];
    assign tag      = req_addr[63 -: TAG_W];
    assign word_lsb = {req_addr[5:3], 6'b0};

    // A flush on the lookup edge wins over a hit so stale lines are never returned.
    assign hit     = valid[idx] && (tag_mem[idx] == tag) && !bus.flush;
    assign install = (state == MISS_WAIT) && bus.idone && !drop && !bus.flush && !reset;

    assign unused_addr_bits = ^bus.fetch_addr[2:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (bus.fetch_req) state_nxt = LOOKUP;
            LOOKUP:    state_nxt = hit ? RESP : MISS_REQ;
            MISS_REQ:  if (bus.ireqack) state_nxt = MISS_WAIT;
            MISS_WAIT: if (bus.idone) state_nxt = RESP;
            RESP:      state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            req_addr      <= '0;
            valid         <= '0;
            drop          <= 1'b0;
            fetch_valid_q <= 1'b0;
            fetch_data_q  <= '0;
            irequest_q    <= 1'b0;
            iaddr_q       <= '0;
            hit_count_q   <= '0;
            miss_count_q  <= '0;
        end else begin
            fetch_valid_q <= (state_nxt == RESP);

            if (state == IDLE && bus.fetch_req) begin
                req_addr <= bus.fetch_addr[63:3];
            end

            if (state == LOOKUP) begin
                if (hit) begin
                    hit_count_q  <= hit_count_q + 32'd1;
                    fetch_data_q <= data_mem[idx][word_lsb +: 64];
                end else begin
                    miss_count_q <= miss_count_q + 32'd1;
                    irequest_q   <= 1'b1;
                    iaddr_q      <= {req_addr[63:6], 6'b0};
                end
            end

            if (state == MISS_REQ && bus.ireqack) begin
                irequest_q <= 1'b0;
            end

            if (state == MISS_WAIT && bus.idone) begin
                fetch_data_q <= bus.idata[word_lsb +: 64];
            end

            // The drop flag remembers a flush seen while the fill was outstanding.
            if (state_nxt == RESP) begin
                drop <= 1'b0;
            end else if (bus.flush && (state == MISS_REQ || state == MISS_WAIT)) begin
                drop <= 1'b1;
            end

            if (bus.flush) begin
                valid <= '0;
            end else if (install) begin
                valid[idx] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (install) begin
            data_mem[idx] <= bus.idata;
            tag_mem[idx]  <= tag;
        end
    end

    assign bus.fetch_valid = fetch_valid_q;
    assign bus.fetch_data  = fetch_data_q;
    assign bus.irequest    = irequest_q;
    assign bus.iaddr       = iaddr_q;
    assign bus.hit_count   = hit_count_q;
    assign bus.miss_count  = miss_count_q;

    a_idone_in_wait : assert property (@(posedge clk) disable iff (reset)
        bus.idone |-> (state == MISS_WAIT));
    a_ack_in_req : assert property (@(posedge clk) disable iff (reset)
        bus.ireqack |-> (state == MISS_REQ));
endmodule

// File: tb/tb_icache_dm.sv
// Scoreboard bench for icache_dm: directed cases plus randomized fetches against
// a set-to-line-address model of the cache and a fixed backing memory image.
module tb_icache_dm;
    localparam int SETS = 64;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    icache_if bus();

    icache_dm #(.SETS(SETS)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct packed {
        logic [63:0] data;
        logic [31:0] hits;
        logic [31:0] misses;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    int          checks   = 0;
    int          failures = 0;
    bit          model_valid [SETS];
    logic [63:0] model_line  [SETS];
    logic [31:0] exp_hits;
    logic [31:0] exp_misses;
    logic        prev_fv = 1'b0;

    function automatic logic [63:0] mem_word(input logic [63:0] addr);
        logic [63:0] line;
        logic [63:0] k;
        line = addr >> 6;
        k    = (addr >> 3) & 64'd7;
        if (line == (64'h1000_0000 >> 6)) return 64'hA0 + k;
        return (line * 64'h9E37_79B9_7F4A_7C15) ^ (k << 56) ^ 64'h0123_4567;
    endfunction

    function automatic logic [511:0] line_data(input logic [63:0] addr);
        logic [511:0] d;
        logic [63:0]  base;
        base = (addr >> 6) << 6;
        for (int k = 0; k < 8; k++) d[k*64 +: 64] = mem_word(base + 64'(k * 8));
        return d;
    endfunction

    function automatic logic [511:0] junk_line();
        logic [511:0] d;
        for (int k = 0; k < 16; k++) d[k*32 +: 32] = $urandom;
        return d;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic model_reset();
        for (int s = 0; s < SETS; s++) model_valid[s] = 1'b0;
        exp_hits   = '0;
        exp_misses = '0;
    endtask

    task automatic model_flush();
        for (int s = 0; s < SETS; s++) model_valid[s] = 1'b0;
    endtask

    // Monitor: every fetch_valid pops one expected response.
    always @(negedge clk) begin
        if (!reset && bus.fetch_valid) begin
            check("fv_single_cycle", {63'b0, prev_fv}, 64'd0);
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_fetch_valid actual=1 required=0");
            end else begin
                mon_e = exp_q.pop_front();
                check("fetch_data", bus.fetch_data, mon_e.data);
                check("hit_count",  {32'b0, bus.hit_count},  {32'b0, mon_e.hits});
                check("miss_count", {32'b0, bus.miss_count}, {32'b0, mon_e.misses});
            end
        end
        prev_fv = reset ? 1'b0 : bus.fetch_valid;
    end

    // Called at a negedge with the DUT in IDLE; returns at a negedge with the DUT in IDLE.
    // flush_mode: 0 none, 1 during MISS_REQ, 2 in MISS_WAIT before idone, 3 together with idone.
    task automatic do_fetch(input logic [63:0] addr, input int ack_dly, input int done_dly,
                            input int flush_mode);
        bit          exp_hit;
        int          set;
        logic [63:0] line;
        line    = addr >> 6;
        set     = int'(line % SETS);
        exp_hit = model_valid[set] && (model_line[set] == line);
        if (exp_hit) exp_hits++;
        else         exp_misses++;
        exp_q.push_back('{data: mem_word(addr), hits: exp_hits, misses: exp_misses});

        bus.fetch_req  = 1'b1;
        bus.fetch_addr = addr;
        @(negedge clk);
        bus.fetch_addr = {$urandom, $urandom};
        check("lookup_irequest", {63'b0, bus.irequest}, 64'd0);
        @(negedge clk);
        if (exp_hit) begin
            check("hit_fetch_valid", {63'b0, bus.fetch_valid}, 64'd1);
            check("hit_irequest", {63'b0, bus.irequest}, 64'd0);
            bus.fetch_req = 1'b0;
        end else begin
            check("miss_irequest", {63'b0, bus.irequest}, 64'd1);
            check("miss_iaddr", bus.iaddr, (addr >> 6) << 6);
            if (flush_mode == 1) bus.flush = 1'b1;
            for (int i = 0; i < ack_dly; i++) begin
                @(negedge clk);
                bus.flush = 1'b0;
            end
            check("irequest_held", {63'b0, bus.irequest}, 64'd1);
            bus.ireqack = 1'b1;
            @(negedge clk);
            bus.ireqack = 1'b0;
            bus.flush   = 1'b0;
            check("irequest_drop", {63'b0, bus.irequest}, 64'd0);
            for (int i = 0; i < done_dly; i++) @(negedge clk);
            if (flush_mode == 2) begin
                bus.flush = 1'b1;
                @(negedge clk);
                bus.flush = 1'b0;
            end
            if (flush_mode == 3) bus.flush = 1'b1;
            bus.idone = 1'b1;
            bus.idata = line_data(addr);
            @(negedge clk);
            bus.idone = 1'b0;
            bus.flush = 1'b0;
            bus.idata = junk_line();
            check("fill_fetch_valid", {63'b0, bus.fetch_valid}, 64'd1);
            check("fill_irequest", {63'b0, bus.irequest}, 64'd0);
            bus.fetch_req = 1'b0;
            if (flush_mode != 0) begin
                model_flush();
            end else begin
                model_valid[set] = 1'b1;
                model_line[set]  = line;
            end
        end
        @(negedge clk);
    endtask

    task automatic do_flush();
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        model_flush();
        @(negedge clk);
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] addr;
        int          fm;
        reset          = 1'b1;
        bus.fetch_req  = 1'b0;
        bus.fetch_addr = '0;
        bus.flush      = 1'b0;
        bus.ireqack    = 1'b0;
        bus.idone      = 1'b0;
        bus.idata      = junk_line();
        model_reset();
        repeat (3) @(negedge clk);
        check("rst_fetch_valid", {63'b0, bus.fetch_valid}, 64'd0);
        check("rst_fetch_data", bus.fetch_data, 64'd0);
        check("rst_irequest", {63'b0, bus.irequest}, 64'd0);
        check("rst_iaddr", bus.iaddr, 64'd0);
        check("rst_hit_count", {32'b0, bus.hit_count}, 64'd0);
        check("rst_miss_count", {32'b0, bus.miss_count}, 64'd0);
        reset = 1'b0;
        @(negedge clk);

        // Cold miss, hit in the same line, conflict eviction and re-miss.
        do_fetch(64'h1000_0018, 2, 1, 0);
        do_fetch(64'h1000_0038, 0, 0, 0);
        do_fetch(64'h1000_1000, 1, 2, 0);
        do_fetch(64'h1000_0000, 0, 1, 0);
        check("conflict_miss_count", {32'b0, bus.miss_count}, 64'd3);
        check("conflict_hit_count", {32'b0, bus.hit_count}, 64'd1);

        do_flush();
        do_fetch(64'h1000_0018, 1, 0, 0);

        // Flushes racing an outstanding fill: word still returned, line not kept.
        do_fetch(64'h1000_1008, 1, 1, 2);
        do_fetch(64'h1000_1008, 0, 0, 0);
        do_fetch(64'h1000_2020, 0, 0, 3);
        do_fetch(64'h1000_2020, 2, 0, 0);
        do_fetch(64'h1000_3030, 1, 1, 1);
        do_fetch(64'h1000_3030, 0, 0, 0);
        do_fetch(64'h1000_3038, 0, 0, 0);

        // Reset while irequest is high.
        bus.fetch_req  = 1'b1;
        bus.fetch_addr = 64'h1000_0018;
        @(negedge clk);
        @(negedge clk);
        check("pre_reset_irequest", {63'b0, bus.irequest}, 64'd1);
        bus.fetch_req = 1'b0;
        apply_reset();
        check("mid_rst_irequest", {63'b0, bus.irequest}, 64'd0);
        check("mid_rst_fetch_valid", {63'b0, bus.fetch_valid}, 64'd0);
        check("mid_rst_hit_count", {32'b0, bus.hit_count}, 64'd0);
        check("mid_rst_miss_count", {32'b0, bus.miss_count}, 64'd0);
        do_fetch(64'h1000_0018, 2, 1, 0);
        do_fetch(64'h1000_0030, 0, 0, 0);

        for (int n = 0; n < 80; n++) begin
            addr = 64'h2000_0000
                 + 64'($urandom_range(0, 2)) * 64'(SETS * 64)
                 + 64'($urandom_range(0, 5)) * 64'd64
                 + 64'($urandom_range(0, 7)) * 64'd8
                 + 64'($urandom_range(0, 7));
            fm = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 3)) : 0;
            if ($urandom_range(0, 9) == 0) do_flush();
            do_fetch(addr, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), fm);
        end

        repeat (4) @(negedge clk);
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
